// File: rtl/alu_shift_if.sv
// Request/response bundle for the iterative shift/rotate unit.
// Handshake: start is a request taken only while the unit is idle; busy covers the whole operation; done pulses one cycle with r/flags/flags_we valid.
interface alu_shift_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic             start;
   logic [4:0]       op;
   logic             size;
   logic [WIDTH-1:0] a;
   logic [CNT_W-1:0] count;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r;
   logic [5:0]       flags;
   logic [5:0]       flags_we;

   modport master (
      output start, op, size, a, count, cin,
      input  busy, done, r, flags, flags_we
   );

   modport slave (
      input  start, op, size, a, count, cin,
      output busy, done, r, flags, flags_we
   );
endinterface

// File: rtl/alu_shift_seq.sv
// Iterative shift/rotate unit: one bit position per cycle, start/busy/done handshake.
// Optional macro ALU_SHIFT_COUNT_MASK_EN limits the latched count to its low 5 bits.
module alu_shift_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   alu_shift_if.slave  bus,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic             size_q, size_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic             cy_q, cy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [5:0]       flags_q, flags_d;
   logic [5:0]       flags_we_q, flags_we_d;

   logic [CNT_W-1:0] count_eff;
   logic             op_valid;

`ifdef ALU_SHIFT_COUNT_MASK_EN
   logic unused_cnt_hi;
   assign count_eff     = {{(CNT_W-5){1'b0}}, bus.count[4:0]};
   assign unused_cnt_hi = ^bus.count[CNT_W-1:5];
`else
   assign count_eff = bus.count;
`endif

   // Valid codes are 8..15; only the low three bits are kept once accepted.
   assign op_valid = (bus.op[4:3] == 2'b01);

   // Single step over the active width; byte mode leaves bits above 7 untouched.
   logic             msb_bit, left_in, right_in, step_cy;
   logic [WIDTH-1:0] full_x, step_x;
   logic [7:0]       byte_x;

   always_comb begin
      msb_bit = size_q ? x_q[WIDTH-1] : x_q[7];
      case (op_q[2:1])
         2'b00:   left_in = msb_bit;
         2'b01:   left_in = cy_q;
         default: left_in = 1'b0;
      endcase
      case (op_q[2:1])
         2'b00:   right_in = x_q[0];
         2'b01:   right_in = cy_q;
         2'b10:   right_in = 1'b0;
         default: right_in = msb_bit;
      endcase
      if (!op_q[0]) begin
         step_cy = msb_bit;
         full_x  = {x_q[WIDTH-2:0], left_in};
         byte_x  = {x_q[6:0], left_in};
      end else begin
         step_cy = x_q[0];
         full_x  = {right_in, x_q[WIDTH-1:1]};
         byte_x  = {right_in, x_q[7:1]};
      end
      step_x = size_q ? full_x : {x_q[WIDTH-1:8], byte_x};
   end

   // Flags derived from the step that finishes the operation.
   logic       r_msb, r_msb1, v_flag, z_flag;
   logic [5:0] new_flags, new_we;

   always_comb begin
      r_msb  = size_q ? step_x[WIDTH-1] : step_x[7];
      r_msb1 = size_q ? step_x[WIDTH-2] : step_x[6];
      z_flag = size_q ? (step_x == '0) : (step_x[7:0] == 8'h00);
      case (op_q)
         3'd1, 3'd3: v_flag = r_msb ^ r_msb1;
         3'd5:       v_flag = a_msb_q;
         3'd7:       v_flag = 1'b0;
         default:    v_flag = r_msb ^ step_cy;
      endcase
      new_flags = {z_flag, r_msb, ~^step_x[7:0], v_flag, step_cy, 1'b0};
      new_we    = op_q[2] ? 6'b111110 : 6'b000110;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      size_d     = size_q;
      x_d        = x_q;
      cy_d       = cy_q;
      cnt_d      = cnt_q;
      a_msb_d    = a_msb_q;
      r_d        = r_q;
      flags_d    = flags_q;
      flags_we_d = flags_we_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op[2:0];
               size_d  = bus.size;
               x_d     = bus.a;
               cy_d    = bus.cin;
               cnt_d   = count_eff;
               a_msb_d = bus.size ? bus.a[WIDTH-1] : bus.a[7];
               if (!op_valid || count_eff == '0) begin
                  state_d    = ST_DONE;
                  r_d        = bus.a;
                  flags_we_d = 6'b000000;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            x_d   = step_x;
            cy_d  = step_cy;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d    = ST_DONE;
               r_d        = step_x;
               flags_d    = (flags_q & ~new_we) | (new_flags & new_we);
               flags_we_d = new_we;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= 3'd0;
         size_q     <= 1'b0;
         x_q        <= '0;
         cy_q       <= 1'b0;
         cnt_q      <= '0;
         a_msb_q    <= 1'b0;
         r_q        <= '0;
         flags_q    <= 6'b000000;
         flags_we_q <= 6'b000000;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         size_q     <= size_d;
         x_q        <= x_d;
         cy_q       <= cy_d;
         cnt_q      <= cnt_d;
         a_msb_q    <= a_msb_d;
         r_q        <= r_d;
         flags_q    <= flags_d;
         flags_we_q <= flags_we_d;
      end
   end

   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.r        = r_q;
   assign bus.flags    = flags_q;
   assign bus.flags_we = flags_we_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed and random bench for alu_shift_seq with an arithmetic reference model.
module tb_alu_shift_seq;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         vectors;
   int         miscompares;
   logic [5:0] exp_flags;

   alu_shift_if #(.WIDTH(16), .CNT_W(8)) bus ();

   alu_shift_seq #(.WIDTH(16), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int eff_count(input logic [7:0] cnt);
`ifdef ALU_SHIFT_COUNT_MASK_EN
      return int'(cnt) % 32;
`else
      return int'(cnt);
`endif
   endfunction

   // Closed-form result of n shift/rotate steps over an m-bit field.
   task automatic model(input logic [4:0] op, input logic sz, input logic [15:0] a,
                        input int n, input logic ci,
                        output logic [15:0] er, output logic [5:0] ewe);
      longint unsigned v, mask, res, w, rot, mm;
      int m, k;
      logic cy, sign, vf, rm, rm1;
      logic [15:0] amask;
      logic [5:0]  nf;
      if (op < 8 || op > 15 || n == 0) begin
         er  = a;
         ewe = 6'b000000;
         return;
      end
      m     = sz ? 16 : 8;
      mask  = (64'd1 << m) - 1;
      mm    = (64'd1 << (m + 1)) - 1;
      v     = longint'(a) & mask;
      sign  = v[m-1];
      res   = 0;
      cy    = 1'b0;
      case (op)
         5'd8: begin
            k = n % m; res = ((v << k) | (v >> (m - k))) & mask; cy = res[0];
         end
         5'd9: begin
            k = n % m; res = ((v >> k) | (v << (m - k))) & mask; cy = res[m-1];
         end
         5'd10: begin
            k = n % (m + 1); w = (longint'(ci) << m) | v;
            rot = ((w << k) | (w >> (m + 1 - k))) & mm;
            res = rot & mask; cy = rot[m];
         end
         5'd11: begin
            k = n % (m + 1); w = (v << 1) | longint'(ci);
            rot = ((w >> k) | (w << (m + 1 - k))) & mm;
            res = rot >> 1; cy = rot[0];
         end
         5'd12, 5'd14: begin
            res = (n >= m) ? 0 : ((v << n) & mask);
            cy  = (n > m) ? 1'b0 : v[m-n];
         end
         5'd13: begin
            res = (n >= m) ? 0 : (v >> n);
            cy  = (n > m) ? 1'b0 : v[n-1];
         end
         default: begin
            if (n >= m) res = sign ? mask : 0;
            else res = (v >> n) | (sign ? ((mask << (m - n)) & mask) : 0);
            cy = (n > m) ? sign : v[n-1];
         end
      endcase
      amask = mask[15:0];
      er    = (a & ~amask) | res[15:0];
      rm    = er[m-1];
      rm1   = er[m-2];
      case (op)
         5'd9, 5'd11: vf = rm ^ rm1;
         5'd13:       vf = a[m-1];
         5'd15:       vf = 1'b0;
         default:     vf = rm ^ cy;
      endcase
      ewe = (op < 12) ? 6'b000110 : 6'b111110;
      nf  = {(res == 0), rm, ~^er[7:0], vf, cy, 1'b0};
      exp_flags = (exp_flags & ~ewe) | (nf & ewe);
   endtask

   // One operation end to end; stress keeps start high through busy and the done cycle.
   task automatic run_op(input logic [4:0] op, input logic sz, input logic [15:0] a,
                         input logic [7:0] cnt, input logic ci, input bit stress);
      logic [15:0] er;
      logic [5:0]  ewe;
      int n, exp_lat, lat;
      n = eff_count(cnt);
      model(op, sz, a, n, ci, er, ewe);
      exp_lat = (op < 8 || op > 15) ? 1 : n + 1;
      @(negedge clk);
      bus.op    = op;
      bus.size  = sz;
      bus.a     = a;
      bus.count = cnt;
      bus.cin   = ci;
      bus.start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.start = stress;
         bus.a     = ~a;
         bus.count = 8'd0;
         if (lat == 1 && exp_lat > 1) check("busy_early", {bus.busy, bus.done}, 2'b10);
      end while (!bus.done && lat < 400);
      check("latency", lat, exp_lat);
      check("r", bus.r, er);
      check("flags", bus.flags, exp_flags);
      check("flags_we", bus.flags_we, ewe);
      @(negedge clk);
      bus.start = 1'b0;
      check("after_done", {bus.busy, bus.done}, 2'b00);
   endtask

   initial begin
      logic saw_done;
      vectors     = 0;
      miscompares = 0;
      exp_flags   = 6'b000000;
      bus.start   = 1'b0;
      bus.op      = 5'd0;
      bus.size    = 1'b0;
      bus.a       = 16'h0000;
      bus.count   = 8'd0;
      bus.cin     = 1'b0;
      reset       = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy_done", {bus.busy, bus.done}, 2'b00);
      check("rst_r", bus.r, 16'h0000);
      check("rst_flags", {bus.flags, bus.flags_we}, 12'h000);
      reset = 1'b0;

      run_op(5'd12, 1'b1, 16'h8001, 8'd1, 1'b0, 1'b0);
      check("plan_shl_r", bus.r, 16'h0002);
      check("plan_shl_flags", {bus.flags, bus.flags_we}, {6'b000110, 6'b111110});

      run_op(5'd9, 1'b0, 16'hAB01, 8'd1, 1'b0, 1'b0);
      check("plan_ror_r", bus.r, 16'hAB80);
      check("plan_ror_cyv", {bus.flags[2:1], bus.flags_we}, {2'b11, 6'b000110});

      run_op(5'd11, 1'b1, 16'h0001, 8'd17, 1'b0, 1'b0);
      check("plan_rorc_r", {bus.r, bus.flags[1]}, {16'h0001, 1'b0});

      run_op(5'd15, 1'b0, 16'h0080, 8'd3, 1'b0, 1'b0);
      check("plan_shra_r", bus.r, 16'h00F0);
      check("plan_shra_flags", bus.flags[5:1], 5'b01100);

      run_op(5'd13, 1'b1, 16'h5A5A, 8'd0, 1'b1, 1'b1);
      check("plan_cnt0", {bus.r, bus.flags_we}, {16'h5A5A, 6'b000000});

      run_op(5'd8, 1'b1, 16'hC003, 8'd6, 1'b1, 1'b1);
      run_op(5'd3, 1'b1, 16'h1234, 8'd9, 1'b0, 1'b0);

      run_op(5'd12, 1'b1, 16'h0001, 8'h21, 1'b0, 1'b0);
`ifdef ALU_SHIFT_COUNT_MASK_EN
      check("plan_cnt21_r", bus.r, 16'h0002);
`else
      check("plan_cnt21_r", {bus.r, bus.flags[5], bus.flags[1]}, {16'h0000, 1'b1, 1'b0});
`endif

      // Reset in the middle of SHIFT discards the operation silently.
      @(negedge clk);
      bus.op = 5'd12; bus.size = 1'b1; bus.a = 16'h1234; bus.count = 8'd10; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_flags = 6'b000000;
      check("midrst_busy_done", {bus.busy, bus.done}, 2'b00);
      check("midrst_out", {bus.r, bus.flags, bus.flags_we}, 28'h0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         saw_done = saw_done | bus.done | bus.busy;
      end
      check("midrst_no_done", saw_done, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [4:0] op;
         logic [7:0] cnt;
         op  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 15));
         cnt = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
         run_op(op, 1'($urandom_range(0, 1)), 16'($urandom), cnt, 1'($urandom_range(0, 1)),
                bit'($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Iterative multi-cycle shift/rotate unit for the execution stage; successor to the combinational ALU shift path.
- Parametrised in datapath width and count width; adds rotate-through-carry (ROLC/RORC) and arbitrary shift counts.
- Processes one bit position per cycle with a start/busy/done handshake.
- Op codes and flag bit positions match the core ALU: ROL=8, ROR=9, ROLC=10, RORC=11, SHL=12, SHR=13, SHLA=14 (treated as SHL), SHRA=15; flags AC=0, CY=1, V=2, P=3, S=4, Z=5.

Parameters:
- WIDTH, 16: datapath width; must be a multiple of 8 and ≥16; full-size msb = WIDTH-1.
- CNT_W, 8: width of the shift-count input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  5  operation code, 8..15; any other code → R=A, flags_we=0, latency 1.
- size  in  1  0=byte (bits 7:0, upper bits passed through from A), 1=full WIDTH.
- a  in  WIDTH  operand.
- count  in  CNT_W  shift/rotate count.
- cin  in  1  carry in for ROLC/RORC.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; r/flags/flags_we valid this cycle and held until next start.
- r  out  WIDTH  result.
- flags  out  6  flag values.
- flags_we  out  6  mask of flags the consumer must write.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, r=0, flags=0, flags_we=0. Applies mid-operation; the in-flight op is discarded with no done pulse.
- IDLE + start: latch op, size, a, cin, count into internal registers (cnt, cy).
  - cnt==0 → DONE.
  - otherwise → SHIFT.
- SHIFT: one step per cycle over msb (7 or WIDTH-1); decrement cnt; go to DONE when cnt reaches 0.
  - ROL: cy=x[msb]; x=x<<1 | x[msb].
  - ROR: cy=x[0]; x=x>>1 with x[msb]=x[0].
  - ROLC: {cy,x} rotated left through carry; operand effectively msb+2 bits.
  - RORC: {x,cy} rotated right through carry.
  - SHL/SHLA: cy=x[msb]; x<<1, zero-fill.
  - SHR: cy=x[0]; x>>1 with x[msb]=0.
  - SHRA: cy=x[0]; x>>1 with x[msb] kept.
  - Byte mode: only bits 7:0 change; bits WIDTH-1:8 equal a.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency from the start edge to done: cnt+1 cycles (count 0 → 1 cycle).
- start while busy is ignored. start in the DONE cycle is ignored; a new op is accepted the cycle after done.
- Flags when cnt≠0:
  - CY = final cy.
  - V, all ops: rotate/shift-left ops: r[msb]^CY. ROR/RORC: r[msb]^r[msb-1]. SHR: a[msb]. SHRA: 0. V is computed by these rules for any count.
  - SHL/SHLA/SHR/SHRA only: S=r[msb]; Z=(r over active size==0); P = even parity of r[7:0] (1 = even).
  - flags_we: rotates = CY|V; shifts = CY|V|P|S|Z. AC is never written.
- cnt==0: r=a, flags_we=0, flags unchanged from the previous op.

Optional Feature:
- Macro ALU_SHIFT_COUNT_MASK_EN.
- Defined: latched count = count & 5'h1F (upper count bits ignored); worst-case latency 32 cycles.
- Undefined: full CNT_W count is iterated; worst-case latency 2^CNT_W cycles.

Test Plan:
- SHL, size=1, a=16'h8001, count=1 → done 2 cycles after start; r=16'h0002, CY=1, V=1, Z=0, S=0, P=0; flags_we=6'b111110.
- ROR, size=0, a=16'hAB01, count=1 → r=16'hAB80, CY=1, V=1; flags_we=6'b000110.
- RORC, size=1, a=16'h0001, cin=0, count=17 → done 18 cycles after start; r=16'h0001, CY=0 (full 17-bit cycle).
- SHRA, size=0, a=16'h0080, count=3 → r=16'h00F0, CY=0, S=1, Z=0, P=1, V=0.
- count=0 → done 1 cycle after start, r=a, flags_we=0.
  - Second start pulsed while busy is not accepted; exactly one done pulse.
  - reset asserted mid-SHIFT → busy=0 next cycle, no done.
- SHL, size=1, a=16'h0001, count=8'h21:
  - With ALU_SHIFT_COUNT_MASK_EN: r=16'h0002, done at cycle 2.
  - Without: r=0, Z=1, CY=0, done at cycle 34.
